adc_ad4003_deser_mc: RTL and testbench
======================================

// Module: adc_ad4003_deser_mc
// PURPOSE
//  Multi-channel, framed AD4003 serial-data deserializer: successor to the 2-channel free-running shifter.
//  Captures N_CH parallel SDO lines MSB-first on adc_read_clk (80 MHz, delayed clock domain).
//  Bits are counted per frame; at frame end it emits a parallel word per channel, a one-cycle valid pulse and a sample count.
//  Sits between the ADC SPI timing generator (frame_start, reader_en_sync) and the acquisition DMA/packer.
// PARAMETERS
//  ADC_DATA_WIDTH  18  bits per conversion word, 2..32
//  N_CH            8   number of SDO lanes captured in parallel, 1..64
//  CNT_WIDTH       32  width of sample_cnt, wraps modulo 2^CNT_WIDTH
// PORTS
//  adc_read_clk    in   1                     single clock; all logic on its rising edge
//  rst             in   1                     synchronous, active-high reset
//  frame_start     in   1                     1-cycle pulse: next accepted cycle is bit MSB of a new frame
//  reader_en_sync  in   1                     bit-enable; a bit is sampled only in SHIFT with this high
//  adc_sdo         in   N_CH                  SDO lanes, lane k -> channel k
//  adc_data        out  N_CH*ADC_DATA_WIDTH   latched words, ch k at [k*W +: W], W=ADC_DATA_WIDTH
//  data_valid      out  1                     1-cycle pulse: adc_data/sample_cnt updated this cycle
//  sample_cnt      out  CNT_WIDTH             number of completed frames (wraps)
//  busy            out  1                     high while state != IDLE
//  overrun         out  1                     sticky abort flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst=1 at edge): state=IDLE, bit_cnt=0, shift regs=0, adc_data=0, data_valid=0, sample_cnt=0, overrun=0.
//  States: IDLE, SHIFT, DONE (one-hot or binary, implementer's choice).
//  IDLE:  frame_start=1 -> SHIFT, bit_cnt=0; no bit sampled in that cycle. Otherwise stay.
//  SHIFT: reader_en_sync=1 and frame_start=0 -> sr[k] <= {sr[k][W-2:0], adc_sdo[k]}, bit_cnt++.
//         reader_en_sync=0 -> hold (stall); bit_cnt and sr unchanged, no timeout.
//         On the cycle sampling bit index W-1 (bit_cnt==W-1) -> DONE.
//         frame_start=1 in SHIFT (any bit_cnt, incl. W-1) -> abort: partial word discarded, bit_cnt=0,
//         stay in SHIFT (restart frame), bit on that cycle NOT sampled, adc_data unchanged, no data_valid.
//  DONE:  (one cycle) adc_data <= all sr incl. last bit; data_valid=1; sample_cnt++ (wrap all-ones -> 0).
//         frame_start=1 in DONE -> SHIFT with bit_cnt=0 (back-to-back frames, no lost frame); else -> IDLE.
//  Latency: data_valid and new adc_data visible the cycle after the last (W-th) bit is sampled.
//  Minimum frame period: W+1 cycles (frame_start in DONE); frame_start pulses in IDLE/DONE only are never aborts.
//  adc_data holds its last value between frames; data_valid is never high two consecutive cycles.
//  Reset mid-frame: immediate return to reset state; partial word lost, no data_valid.
//  MSB-first: first sampled bit ends at adc_data[k*W+W-1], last at adc_data[k*W].
//  Data is raw two's complement as shifted; no sign extension or arithmetic.
// CONFIGURATION
//  Macro ADC_DESER_OVERRUN_EN:
//   defined:  overrun set to 1 the cycle after a SHIFT-state abort (frame_start in SHIFT); sticky until rst.
//   undefined: overrun tied to 0; abort behaviour otherwise identical.
// TESTING
//  W=18,N_CH=2: frame_start, 18 cycles en=1, ch0 drives 0x2AAAA MSB-first, ch1 0x15555 -> next cycle
//   data_valid=1 one cycle, adc_data[17:0]=0x2AAAA, [35:18]=0x15555, sample_cnt=1, busy=0 after.
//  Same frame with reader_en_sync low for 5 cycles after bit 9 -> identical words, data_valid 5 cycles later.
//  frame_start again after bit 10 (bit_cnt=10), then 18 clean bits 0x3FFFF -> only one valid, word=0x3FFFF,
//   sample_cnt=1; overrun=1 with ADC_DESER_OVERRUN_EN, 0 without.
//  Back-to-back: frame_start in each DONE cycle, 4 frames 0x00001,0x00002,0x20000,0x3FFFF -> 4 valid pulses
//   exactly 19 cycles apart, words in order, sample_cnt 1..4.
//  CNT_WIDTH=4: 17 frames -> sample_cnt 15 then 0 then 1.
//  rst asserted at bit 7 of a frame -> all outputs 0 next cycle; no data_valid until a fresh full frame.

Source files
------------

// File: rtl/adc_ad4003_deser_mc.sv
// -----------------------------------------------------------------------------
// adc_ad4003_deser_mc
// Framed multi-channel AD4003 SDO deserializer. N_CH lanes are shifted in
// MSB-first, one bit per enabled cycle, and latched together as parallel words
// at the end of every ADC_DATA_WIDTH-bit frame. Each completed frame produces a
// one-cycle data_valid pulse and increments a wrapping sample counter.
//
// Optional feature macro: ADC_DESER_OVERRUN_EN
//   defined   -> overrun is a sticky flag raised by a frame_start that
//                arrives while a frame is still being shifted in
//   undefined -> overrun is tied to 0 (abort behaviour is unchanged)
// -----------------------------------------------------------------------------
module adc_ad4003_deser_mc #(
   parameter int ADC_DATA_WIDTH = 18,
   parameter int N_CH           = 8,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                             adc_read_clk,
   input  logic                             rst,
   input  logic                             frame_start,
   input  logic                             reader_en_sync,
   input  logic [N_CH-1:0]                  adc_sdo,
   output logic [N_CH*ADC_DATA_WIDTH-1:0]   adc_data,
   output logic                             data_valid,
   output logic [CNT_WIDTH-1:0]             sample_cnt,
   output logic                             busy,
   output logic                             overrun
);

   localparam int W   = ADC_DATA_WIDTH;
   localparam int BCW = (W > 2) ? $clog2(W) : 1;

   // Bit index of the final (LSB) bit of a frame.
   localparam logic [BCW-1:0] LAST_BIT = BCW'(W - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Per-lane word type; a packed array of these flattens so that channel k
   // lands at [k*W +: W] of the output bus.
   typedef logic [W-1:0] word_t;

   state_t                     state_q;
   logic [BCW-1:0]             bit_cnt_q;
   logic [N_CH-1:0][W-1:0]     sr_q;
   logic [N_CH-1:0][W-1:0]     sr_d;
   logic [N_CH-1:0][W-1:0]     adc_data_q;
   logic                       data_valid_q;
   logic [CNT_WIDTH-1:0]       sample_cnt_q;
   logic                       busy_q;

   // Next contents of every lane's shift register if the current SDO bit is taken.
   always_comb begin
      // NOTE: every combinational output gets a default before any loop or
      // branch, so no path can leave it unassigned and infer a latch.
      sr_d = '0;
      for (int k = 0; k < N_CH; k++) begin
         sr_d[k] = {sr_q[k][W-2:0], adc_sdo[k]};
      end
   end

   // Frame FSM: bit counting, shifting, word latch, valid pulse and sample count.
   always_ff @(posedge adc_read_clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= '0;
         // NOTE: the shift registers are cleared on reset like any other state
         // so a frame aborted by reset cannot leak stale bits into a later word.
         sr_q         <= '0;
         adc_data_q   <= '0;
         data_valid_q <= 1'b0;
         sample_cnt_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         // NOTE: all sequential state uses non-blocking assignments, so every
         // right-hand side below sees the pre-edge value of each register.
         data_valid_q <= 1'b0;

         case (state_q)
            ST_IDLE: begin
               // A start pulse only arms the frame; the MSB arrives on a later cycle.
               if (frame_start) begin
                  state_q   <= ST_SHIFT;
                  bit_cnt_q <= '0;
                  sr_q      <= '0;
                  busy_q    <= 1'b1;
               end
            end

            ST_SHIFT: begin
               if (frame_start) begin
                  // Abort: drop the partial word and restart the frame in place.
                  bit_cnt_q <= '0;
                  sr_q      <= '0;
               end else if (reader_en_sync) begin
                  sr_q <= sr_d;
                  if (bit_cnt_q == LAST_BIT) begin
                     // Last bit: publish all lanes together with the valid pulse.
                     adc_data_q   <= sr_d;
                     data_valid_q <= 1'b1;
                     sample_cnt_q <= sample_cnt_q + CNT_WIDTH'(1);
                     bit_cnt_q    <= '0;
                     state_q      <= ST_DONE;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + BCW'(1);
                  end
               end
               // reader_en_sync low: stall with count and shift registers held.
            end

            ST_DONE: begin
               // A start pulse here chains directly into the next frame.
               if (frame_start) begin
                  state_q   <= ST_SHIFT;
                  bit_cnt_q <= '0;
                  sr_q      <= '0;
                  busy_q    <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q   <= ST_IDLE;
               bit_cnt_q <= '0;
               busy_q    <= 1'b0;
            end
         endcase
      end
   end

`ifdef ADC_DESER_OVERRUN_EN
   logic overrun_q;

   // Sticky record that a frame was aborted by an early frame_start.
   always_ff @(posedge adc_read_clk) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else if ((state_q == ST_SHIFT) && frame_start) begin
         overrun_q <= 1'b1;
      end
   end

   assign overrun = overrun_q;
`else
   assign overrun = 1'b0;
`endif

   assign adc_data   = adc_data_q;
   assign data_valid = data_valid_q;
   assign sample_cnt = sample_cnt_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_adc_ad4003_deser_mc.sv
// -----------------------------------------------------------------------------
// tb_adc_ad4003_deser_mc
// Directed bench for adc_ad4003_deser_mc with W=18, N_CH=2. A second instance
// with CNT_WIDTH=4 shares all inputs so that counter wrap can be observed.
// Expected overrun behaviour follows ADC_DESER_OVERRUN_EN.
// -----------------------------------------------------------------------------
module tb_adc_ad4003_deser_mc;

   localparam int W    = 18;
   localparam int N_CH = 2;

`ifdef ADC_DESER_OVERRUN_EN
   localparam logic OVR_EXP = 1'b1;
`else
   localparam logic OVR_EXP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic              frame_start;
   logic              reader_en_sync;
   logic [N_CH-1:0]   adc_sdo;

   logic [N_CH*W-1:0] adc_data;
   logic              data_valid;
   logic [31:0]       sample_cnt;
   logic              busy;
   logic              overrun;

   logic [N_CH*W-1:0] adc_data4;
   logic              data_valid4;
   logic [3:0]        sample_cnt4;
   logic              busy4;
   logic              overrun4;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   adc_ad4003_deser_mc #(
      .ADC_DATA_WIDTH (W),
      .N_CH           (N_CH),
      .CNT_WIDTH      (32)
   ) dut (
      .adc_read_clk   (clk),
      .rst            (rst),
      .frame_start    (frame_start),
      .reader_en_sync (reader_en_sync),
      .adc_sdo        (adc_sdo),
      .adc_data       (adc_data),
      .data_valid     (data_valid),
      .sample_cnt     (sample_cnt),
      .busy           (busy),
      .overrun        (overrun)
   );

   adc_ad4003_deser_mc #(
      .ADC_DATA_WIDTH (W),
      .N_CH           (N_CH),
      .CNT_WIDTH      (4)
   ) dut_cnt4 (
      .adc_read_clk   (clk),
      .rst            (rst),
      .frame_start    (frame_start),
      .reader_en_sync (reader_en_sync),
      .adc_sdo        (adc_sdo),
      .adc_data       (adc_data4),
      .data_valid     (data_valid4),
      .sample_cnt     (sample_cnt4),
      .busy           (busy4),
      .overrun        (overrun4)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs set before the call are sampled at that edge,
   // outputs are read 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      frame_start    = 1'b0;
      reader_en_sync = 1'b0;
      adc_sdo        = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic start_frame();
      frame_start    = 1'b1;
      reader_en_sync = 1'b0;
      tick();
      frame_start = 1'b0;
   endtask

   // Drive bit indices [first..last] of w0 (lane 0) and w1 (lane 1), MSB-first.
   task automatic drive_bits(input logic [W-1:0] w0, input logic [W-1:0] w1,
                             input int first, input int last);
      for (int i = first; i <= last; i++) begin
         reader_en_sync = 1'b1;
         adc_sdo[0]     = w0[W-1-i];
         adc_sdo[1]     = w1[W-1-i];
         tick();
      end
      reader_en_sync = 1'b0;
      adc_sdo        = '0;
   endtask

   task automatic abort_cycle();
      frame_start    = 1'b1;
      reader_en_sync = 1'b1;
      adc_sdo        = 2'b11;
      tick();
      frame_start    = 1'b0;
      reader_en_sync = 1'b0;
      adc_sdo        = '0;
   endtask

   initial begin
      int t0;
      int last_valid;
      logic [W-1:0] b2b_words [4];

      b2b_words[0] = 18'h00001;
      b2b_words[1] = 18'h00002;
      b2b_words[2] = 18'h20000;
      b2b_words[3] = 18'h3FFFF;

      // ---- reset state ----
      do_reset();
      check("rst data",  adc_data,   36'h0);
      check("rst valid", data_valid, 1'b0);
      check("rst cnt",   sample_cnt, 32'd0);
      check("rst busy",  busy,       1'b0);
      check("rst ovr",   overrun,    1'b0);

      // ---- basic frame ----
      t0 = cyc;
      start_frame();
      check("t1 busy armed", busy, 1'b1);
      drive_bits(18'h2AAAA, 18'h15555, 0, 16);
      check("t1 no early valid", data_valid, 1'b0);
      drive_bits(18'h2AAAA, 18'h15555, 17, 17);
      check("t1 valid",   data_valid, 1'b1);
      check("t1 data",    adc_data,   {18'h15555, 18'h2AAAA});
      check("t1 cnt",     sample_cnt, 32'd1);
      check("t1 latency", cyc - t0,   19);
      tick();
      check("t1 valid drop", data_valid, 1'b0);
      check("t1 busy idle",  busy,       1'b0);
      check("t1 data hold",  adc_data,   {18'h15555, 18'h2AAAA});

      // ---- same frame with a 5-cycle stall after bit 9 ----
      t0 = cyc;
      start_frame();
      drive_bits(18'h2AAAA, 18'h15555, 0, 9);
      for (int s = 0; s < 5; s++) tick();
      check("t2 stall busy",  busy,       1'b1);
      check("t2 stall valid", data_valid, 1'b0);
      drive_bits(18'h2AAAA, 18'h15555, 10, 17);
      check("t2 valid",   data_valid, 1'b1);
      check("t2 data",    adc_data,   {18'h15555, 18'h2AAAA});
      check("t2 cnt",     sample_cnt, 32'd2);
      check("t2 latency", cyc - t0,   24);
      tick();

      // ---- abort at bit_cnt=10, then a clean frame ----
      do_reset();
      start_frame();
      drive_bits(18'h12345, 18'h12345, 0, 9);
      abort_cycle();
      check("t3 abort valid", data_valid, 1'b0);
      check("t3 abort busy",  busy,       1'b1);
      check("t3 abort data",  adc_data,   36'h0);
      check("t3 abort ovr",   overrun,    OVR_EXP);
      drive_bits(18'h3FFFF, 18'h3FFFF, 0, 17);
      check("t3 valid", data_valid, 1'b1);
      check("t3 data",  adc_data,   {18'h3FFFF, 18'h3FFFF});
      check("t3 cnt",   sample_cnt, 32'd1);
      tick();
      check("t3 ovr sticky", overrun, OVR_EXP);

      // ---- abort on the last-bit cycle ----
      start_frame();
      drive_bits(18'h0F0F0, 18'h30F0F, 0, 16);
      abort_cycle();
      check("t3b abort valid", data_valid, 1'b0);
      check("t3b data hold",   adc_data,   {18'h3FFFF, 18'h3FFFF});
      drive_bits(18'h0F0F0, 18'h30F0F, 0, 17);
      check("t3b valid", data_valid, 1'b1);
      check("t3b data",  adc_data,   {18'h30F0F, 18'h0F0F0});
      check("t3b cnt",   sample_cnt, 32'd2);
      tick();

      // ---- back-to-back frames, frame_start in DONE ----
      do_reset();
      last_valid = 0;
      for (int f = 0; f < 4; f++) begin
         if (f == 0) begin
            start_frame();
         end else begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            check("b2b valid gap", data_valid, 1'b0);
         end
         drive_bits(b2b_words[f], ~b2b_words[f], 0, 17);
         check("b2b valid", data_valid, 1'b1);
         check("b2b data",  adc_data,   {~b2b_words[f], b2b_words[f]});
         check("b2b cnt",   sample_cnt, 64'(f + 1));
         if (f > 0) check("b2b period", cyc - last_valid, 19);
         last_valid = cyc;
      end
      tick();
      check("b2b busy idle", busy, 1'b0);

      // ---- counter wrap, CNT_WIDTH=4 instance ----
      do_reset();
      for (int f = 1; f <= 17; f++) begin
         start_frame();
         drive_bits(18'(f * 1001), 18'(f * 77), 0, 17);
         if (f >= 15) begin
            check("wrap cnt4",  sample_cnt4, 64'(f % 16));
            check("wrap cnt32", sample_cnt,  64'(f));
            check("wrap valid4", data_valid4, 1'b1);
         end
         tick();
      end

      // ---- reset at bit 7 of a frame ----
      start_frame();
      drive_bits(18'h2AAAA, 18'h15555, 0, 6);
      rst = 1'b1;
      tick();
      check("mid rst data",  adc_data,    36'h0);
      check("mid rst valid", data_valid,  1'b0);
      check("mid rst cnt",   sample_cnt,  32'd0);
      check("mid rst cnt4",  sample_cnt4, 4'd0);
      check("mid rst busy",  busy,        1'b0);
      check("mid rst ovr",   overrun,     1'b0);
      rst = 1'b0;
      drive_bits(18'h2AAAA, 18'h15555, 7, 17);
      check("mid rst no valid", data_valid, 1'b0);
      check("mid rst no busy",  busy,       1'b0);
      start_frame();
      drive_bits(18'h2AAAA, 18'h15555, 0, 17);
      check("fresh valid", data_valid, 1'b1);
      check("fresh data",  adc_data,   {18'h15555, 18'h2AAAA});
      check("fresh cnt",   sample_cnt, 32'd1);
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
